// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_bus_arbiter
//  Description : DMA bus-hold arbiter placed between the 8088 status bus and
//                the DMA engine. It asks for the system bus, waits for a
//                processor-passive cycle, then sequences HOLD -> WAIT -> GRANT
//                for one channel at a time. The full bus address is formed
//                from a per-channel page register file.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock            : system clock; all state changes on the rising edge
//    reset_n          : asynchronous active-low reset
//    processor_status : 8088 S2..S0 (3'b111 = passive)
//    processor_lock_n : CPU LOCK#; low keeps the bus with the CPU
//    request          : per-channel DMA request, level, active-high
//    release_strobe   : end-of-transfer pulse from the granted channel
//    grant_n          : per-channel DMA acknowledge, one-cold
//    hold_acknowledge : high while the DMA side owns the bus
//    address_enable_n : AEN; high while the DMA side drives the address
//    dma_wait_n       : CPU wait, low for the single cycle before a grant
//    active_channel   : index of the latched arbitration winner
//    cpu_address      : CPU address
//    dma_offset       : DMA engine address offset (low address bits)
//    page_write       : page register write strobe
//    page_select      : page register index
//    page_data        : page register write data
//    address          : muxed system address (combinational)
// ============================================================================
module dma_bus_arbiter #(
    parameter int CHANNELS   = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int PAGE_WIDTH = 4,
    parameter int ROTATE     = 0,
    parameter int SEL_W      = $clog2(CHANNELS)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [2:0]                       processor_status,
    input  logic                             processor_lock_n,
    input  logic [CHANNELS-1:0]              request,
    input  logic                             release_strobe,
    output logic [CHANNELS-1:0]              grant_n,
    output logic                             hold_acknowledge,
    output logic                             address_enable_n,
    output logic                             dma_wait_n,
    output logic [SEL_W-1:0]                 active_channel,
    input  logic [ADDR_WIDTH-1:0]            cpu_address,
    input  logic [ADDR_WIDTH-PAGE_WIDTH-1:0] dma_offset,
    input  logic                             page_write,
    input  logic [SEL_W-1:0]                 page_select,
    input  logic [PAGE_WIDTH-1:0]            page_data,
    output logic [ADDR_WIDTH-1:0]            address
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_HOLD    = 3'd2,
        S_WAIT    = 3'd3,
        S_GRANT   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t                 r_state;
    logic [CHANNELS-1:0]    r_grant_n;
    logic                   r_hold_ack;
    logic                   r_aen_n;
    logic                   r_dma_wait_n;
    logic [SEL_W-1:0]       r_active;
    logic [SEL_W-1:0]       r_rotate_ptr;
    logic [PAGE_WIDTH-1:0]  r_page [CHANNELS];

    logic [SEL_W-1:0]       w_start;
    logic [SEL_W-1:0]       w_winner;
    logic                   w_found;
    logic [SEL_W:0]         w_idx;
    logic [CHANNELS-1:0]    w_grant_cold;
    logic                   w_page_in_range;

    // Fixed priority always searches from channel 0; rotating priority
    // starts at the channel after the last one served.
    assign w_start = (ROTATE != 0) ? r_rotate_ptr : '0;

    // Circular first-set search starting at w_start, wrapping at CHANNELS-1.
    always_comb begin
        w_winner = w_start;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_idx = {1'b0, w_start} + (SEL_W+1)'(i);
            if (w_idx >= (SEL_W+1)'(CHANNELS)) begin
                w_idx = w_idx - (SEL_W+1)'(CHANNELS);
            end
            if (!w_found && request[w_idx[SEL_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant_cold           = '1;
        w_grant_cold[r_active] = 1'b0;
    end

    // Non-power-of-two channel counts leave unused select codes; drop them.
    assign w_page_in_range = ({1'b0, page_select} < (SEL_W+1)'(CHANNELS));

    // Output registers are loaded with the values of the state being entered,
    // so every control output is a clean flop output aligned with r_state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_grant_n    <= '1;
            r_hold_ack   <= 1'b0;
            r_aen_n      <= 1'b0;
            r_dma_wait_n <= 1'b1;
            r_active     <= '0;
            r_rotate_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|request) begin
                        r_state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (request == '0) begin
                        r_state <= S_IDLE;
                    end else if (processor_status == 3'b111 && processor_lock_n) begin
                        r_state    <= S_HOLD;
                        r_hold_ack <= 1'b1;
                        r_aen_n    <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (request == '0) begin
                        r_state    <= S_RELEASE;
                        r_hold_ack <= 1'b0;
                    end else begin
                        r_state      <= S_WAIT;
                        r_active     <= w_winner;
                        r_dma_wait_n <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_dma_wait_n <= 1'b1;
                    if (request[r_active]) begin
                        r_state   <= S_GRANT;
                        r_grant_n <= w_grant_cold;
                    end else begin
                        r_state    <= S_RELEASE;
                        r_hold_ack <= 1'b0;
                    end
                end
                S_GRANT: begin
                    // Other channels are not looked at until the next
                    // arbitration pass through HOLD.
                    if (!request[r_active] || release_strobe) begin
                        r_state    <= S_RELEASE;
                        r_grant_n  <= '1;
                        r_hold_ack <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                    r_aen_n <= 1'b0;
                    if (ROTATE != 0) begin
                        r_rotate_ptr <= (r_active == SEL_W'(CHANNELS-1)) ? '0 : r_active + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_grant_n    <= '1;
                    r_hold_ack   <= 1'b0;
                    r_aen_n      <= 1'b0;
                    r_dma_wait_n <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_page[i] <= '0;
            end
        end else if (page_write && w_page_in_range) begin
            r_page[page_select] <= page_data;
        end
    end

    assign grant_n          = r_grant_n;
    assign hold_acknowledge = r_hold_ack;
    assign address_enable_n = r_aen_n;
    assign dma_wait_n       = r_dma_wait_n;
    assign active_channel   = r_active;

    // The page is presented from WAIT onward so the address is stable
    // before the acknowledge is asserted.
    assign address = (r_state == S_GRANT || r_state == S_WAIT) ?
                     {r_page[r_active], dma_offset} : cpu_address;

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module      : tb_dma_bus_arbiter
//  Description : Self-checking bench for dma_bus_arbiter. Two instances share
//                the stimulus: one with fixed priority, one with rotating
//                priority. Expected grants are queued by the stimulus and
//                popped by per-instance monitors when a grant appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_bus_arbiter;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [19:0] addr;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [2:0]  processor_status;
    logic        processor_lock_n;
    logic [3:0]  request;
    logic        release_strobe;
    logic [19:0] cpu_address;
    logic [15:0] dma_offset;
    logic        page_write;
    logic [1:0]  page_select;
    logic [3:0]  page_data;

    logic [3:0]  grant_n_f, grant_n_r;
    logic        hold_f, hold_r, aen_f, aen_r, wait_f, wait_r;
    logic [1:0]  act_f, act_r;
    logic [19:0] addr_f, addr_r;

    exp_t        q_fix[$];
    exp_t        q_rot[$];
    logic [3:0]  pm [4];
    int          checks   = 0;
    int          failures = 0;

    dma_bus_arbiter #(.CHANNELS(4), .ADDR_WIDTH(20), .PAGE_WIDTH(4), .ROTATE(0)) u_dut_fix (
        .clock(clock), .reset_n(reset_n), .processor_status(processor_status),
        .processor_lock_n(processor_lock_n), .request(request), .release_strobe(release_strobe),
        .grant_n(grant_n_f), .hold_acknowledge(hold_f), .address_enable_n(aen_f),
        .dma_wait_n(wait_f), .active_channel(act_f), .cpu_address(cpu_address),
        .dma_offset(dma_offset), .page_write(page_write), .page_select(page_select),
        .page_data(page_data), .address(addr_f)
    );

    dma_bus_arbiter #(.CHANNELS(4), .ADDR_WIDTH(20), .PAGE_WIDTH(4), .ROTATE(1)) u_dut_rot (
        .clock(clock), .reset_n(reset_n), .processor_status(processor_status),
        .processor_lock_n(processor_lock_n), .request(request), .release_strobe(release_strobe),
        .grant_n(grant_n_r), .hold_acknowledge(hold_r), .address_enable_n(aen_r),
        .dma_wait_n(wait_r), .active_channel(act_r), .cpu_address(cpu_address),
        .dma_offset(dma_offset), .page_write(page_write), .page_select(page_select),
        .page_data(page_data), .address(addr_r)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // {grant_n, hold_acknowledge, address_enable_n, dma_wait_n} on both instances
    task automatic chk_ctrl(input string name, input logic [3:0] g, input logic h,
                            input logic a, input logic w);
        chk({name, "_fix"}, {25'd0, grant_n_f, hold_f, aen_f, wait_f}, {25'd0, g, h, a, w});
        chk({name, "_rot"}, {25'd0, grant_n_r, hold_r, aen_r, wait_r}, {25'd0, g, h, a, w});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write_page(input logic [1:0] s, input logic [3:0] d);
        page_select = s;
        page_data   = d;
        page_write  = 1'b1;
        step(1);
        page_write  = 1'b0;
        pm[s]       = d;
    endtask

    task automatic wait_grant(input int bound);
        int n;
        n = 0;
        while (grant_n_f == 4'hF && n < bound) begin
            step(1);
            n++;
        end
        checks++;
        if (grant_n_f == 4'hF) begin
            failures++;
            $display("FAIL wait_grant timeout actual=%0h expected=not_all_ones", grant_n_f);
        end
    endtask

    // Monitors: a fresh grant (all-ones -> one-cold) pops the next expectation.
    initial begin : g_mon_fix
        logic [3:0] prev;
        exp_t       e;
        prev = 4'hF;
        forever begin
            @(negedge clock);
            if (grant_n_f != 4'hF && prev == 4'hF) begin
                if (q_fix.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fix_unexpected_grant actual=%0h expected=none", grant_n_f);
                end else begin
                    e = q_fix.pop_front();
                    chk("fix_grant_n", {28'd0, grant_n_f}, {28'd0, e.gnt});
                    chk("fix_grant_addr", {12'd0, addr_f}, {12'd0, e.addr});
                end
            end
            prev = grant_n_f;
        end
    end

    initial begin : g_mon_rot
        logic [3:0] prev;
        exp_t       e;
        prev = 4'hF;
        forever begin
            @(negedge clock);
            if (grant_n_r != 4'hF && prev == 4'hF) begin
                if (q_rot.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rot_unexpected_grant actual=%0h expected=none", grant_n_r);
                end else begin
                    e = q_rot.pop_front();
                    chk("rot_grant_n", {28'd0, grant_n_r}, {28'd0, e.gnt});
                    chk("rot_grant_addr", {12'd0, addr_r}, {12'd0, e.addr});
                end
            end
            prev = grant_n_r;
        end
    end

    initial begin : g_watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : g_stim
        logic [3:0] g;
        reset_n          = 1'b0;
        processor_status = 3'b000;
        processor_lock_n = 1'b1;
        request          = 4'd0;
        release_strobe   = 1'b0;
        cpu_address      = 20'h12345;
        dma_offset       = 16'd0;
        page_write       = 1'b0;
        page_select      = 2'd0;
        page_data        = 4'd0;
        for (int i = 0; i < 4; i++) pm[i] = 4'd0;

        // Reset state
        step(2);
        chk_ctrl("reset_state", 4'hF, 1'b0, 1'b0, 1'b1);
        chk("reset_active", {30'd0, act_r}, 32'd0);
        chk("reset_addr", {12'd0, addr_f}, {12'd0, cpu_address});
        reset_n = 1'b1;
        step(1);

        write_page(2'd0, 4'h1);
        write_page(2'd1, 4'h2);
        write_page(2'd2, 4'h5);
        write_page(2'd3, 4'h7);

        // Single request on channel 2: SYNC, HOLD, WAIT, GRANT
        processor_status = 3'b111;
        processor_lock_n = 1'b1;
        dma_offset       = 16'hBEEF;
        request          = 4'b0100;
        q_fix.push_back('{gnt: 4'b1011, addr: {pm[2], 16'hBEEF}});
        q_rot.push_back('{gnt: 4'b1011, addr: {pm[2], 16'hBEEF}});
        step(1); chk_ctrl("t2_sync",  4'hF, 1'b0, 1'b0, 1'b1);
        step(1); chk_ctrl("t2_hold",  4'hF, 1'b1, 1'b1, 1'b1);
        step(1); chk_ctrl("t2_wait",  4'hF, 1'b1, 1'b1, 1'b0);
        chk("t2_wait_addr", {12'd0, addr_f}, {12'd0, 4'h5, 16'hBEEF});
        step(1); chk_ctrl("t2_grant", 4'b1011, 1'b1, 1'b1, 1'b1);
        chk("t2_active", {30'd0, act_f}, 32'd2);
        // Release and request drop together: one RELEASE cycle, then IDLE
        request        = 4'd0;
        release_strobe = 1'b1;
        step(1); chk_ctrl("t2_release", 4'hF, 1'b0, 1'b1, 1'b1);
        release_strobe = 1'b0;
        step(1); chk_ctrl("t2_idle",  4'hF, 1'b0, 1'b0, 1'b1);
        chk("t2_idle_addr", {12'd0, addr_r}, {12'd0, cpu_address});
        step(1); chk_ctrl("t2_idle2", 4'hF, 1'b0, 1'b0, 1'b1);

        // LOCK# holds the arbiter in SYNC
        processor_lock_n = 1'b0;
        dma_offset       = 16'h1234;
        request          = 4'b0001;
        q_fix.push_back('{gnt: 4'b1110, addr: {pm[0], 16'h1234}});
        q_rot.push_back('{gnt: 4'b1110, addr: {pm[0], 16'h1234}});
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_ctrl("t3_locked", 4'hF, 1'b0, 1'b0, 1'b1);
        end
        processor_lock_n = 1'b1;
        wait_grant(6);
        chk_ctrl("t3_granted", 4'b1110, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset in the middle of GRANT
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #0.5;
        chk_ctrl("t4_async_reset", 4'hF, 1'b0, 1'b0, 1'b1);
        request = 4'd0;
        #0.5;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) pm[i] = 4'd0;
        step(1);
        chk_ctrl("t4_idle_after_reset", 4'hF, 1'b0, 1'b0, 1'b1);

        // Rotating vs fixed priority with all channels requesting
        write_page(2'd0, 4'h8);
        write_page(2'd1, 4'h9);
        write_page(2'd2, 4'hA);
        write_page(2'd3, 4'hB);
        dma_offset = 16'h0F0F;
        for (int k = 0; k < 5; k++) begin
            g          = 4'hF;
            g[k % 4]   = 1'b0;
            q_fix.push_back('{gnt: 4'b1110, addr: {pm[0], 16'h0F0F}});
            q_rot.push_back('{gnt: g, addr: {pm[k % 4], 16'h0F0F}});
        end
        request = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_grant(8);
            release_strobe = 1'b1;
            step(1);
            release_strobe = 1'b0;
        end
        request = 4'd0;
        step(3);

        // Request dropped during WAIT: no grant, AEN back low two cycles later
        request = 4'b0010;
        step(3); chk_ctrl("t5_wait",    4'hF, 1'b1, 1'b1, 1'b0);
        request = 4'd0;
        step(1); chk_ctrl("t5_release", 4'hF, 1'b0, 1'b1, 1'b1);
        step(1); chk_ctrl("t5_idle",    4'hF, 1'b0, 1'b0, 1'b1);

        // Page rewrite while channel 3 holds the grant
        dma_offset = 16'hCAFE;
        request    = 4'b1000;
        q_fix.push_back('{gnt: 4'b0111, addr: {pm[3], 16'hCAFE}});
        q_rot.push_back('{gnt: 4'b0111, addr: {pm[3], 16'hCAFE}});
        wait_grant(8);
        @(negedge clock);
        #1;
        write_page(2'd3, 4'hA);
        chk("t6_page_rot", {12'd0, addr_r}, {12'd0, 4'hA, 16'hCAFE});
        chk("t6_page_fix", {12'd0, addr_f}, {12'd0, 4'hA, 16'hCAFE});
        write_page(2'd1, 4'hF);
        chk("t6_other_page", {12'd0, addr_f}, {12'd0, 4'hA, 16'hCAFE});
        chk_ctrl("t6_still_granted", 4'b0111, 1'b1, 1'b1, 1'b1);
        request = 4'd0;
        step(3);

        chk("q_fix_drained", q_fix.size(), 32'd0);
        chk("q_rot_drained", q_rot.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
